// File: rtl/ccr_unit.sv
// Condition-code register with branch-condition evaluation and a LIFO flag-save
// stack for interrupt entry (save) and RTI (restore).
module ccr_unit #(
  parameter int unsigned STACK_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       alu_c,
  input  logic       alu_v,
  input  logic       alu_n,
  input  logic       alu_z,
  input  logic       flag_we,
  input  logic [1:0] cond_sel,
  input  logic       branch_req,
  output logic       branch_taken,
  input  logic       save,
  input  logic       restore,
  output logic       flag_c,
  output logic       flag_v,
  output logic       flag_n,
  output logic       flag_z,
  output logic       stack_full,
  output logic       stack_empty,
  output logic       err
);

  localparam int unsigned CW = $clog2(STACK_DEPTH + 1);
  localparam int unsigned AW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  // CCR layout {Z,N,C,V}: cond_sel 0..3 maps to bit 3..0, i.e. bit index ~cond_sel.
  logic [3:0]    ccr;
  logic [3:0]    ccr_next;
  logic [3:0]    upd;
  logic [CW-1:0] count;
  logic [CW-1:0] count_next;
  logic [3:0]    stack_mem [STACK_DEPTH];
  logic [AW-1:0] push_idx;
  logic [AW-1:0] top_idx;
  logic          collide;
  logic          do_pop;
  logic          do_push;
  logic          fault;

  assign branch_taken = branch_req & ccr[~cond_sel];

  assign flag_z = ccr[3];
  assign flag_n = ccr[2];
  assign flag_c = ccr[1];
  assign flag_v = ccr[0];

  assign stack_full  = (count == CW'(STACK_DEPTH));
  assign stack_empty = (count == '0);

  assign push_idx = count[AW-1:0];
  assign top_idx  = AW'(count - CW'(1));

  always_comb begin
    upd = flag_we ? {alu_z, alu_n, alu_c, alu_v} : ccr;
    // Taken-clear is applied on top of the ALU write so the clear wins.
    if (branch_taken) begin
      upd[~cond_sel] = 1'b0;
    end

    collide = save & restore;
    do_pop  = restore & ~save & ~stack_empty;
    do_push = save & ~restore & ~stack_full;
    fault   = collide
            | (restore & ~save & stack_empty)
            | (save & ~restore & stack_full);

    ccr_next   = do_pop ? stack_mem[top_idx] : upd;
    count_next = count;
    if (do_pop) begin
      count_next = count - CW'(1);
    end else if (do_push) begin
      count_next = count + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ccr   <= '0;
      count <= '0;
      err   <= 1'b0;
    end else begin
      ccr   <= ccr_next;
      count <= count_next;
      err   <= err | fault;
    end
  end

  // Stack contents are don't-care after reset; the pushed value is the pre-edge CCR.
  always_ff @(posedge clk) begin
    if (do_push) begin
      stack_mem[push_idx] <= ccr;
    end
  end

endmodule

// File: tb/tb_ccr_unit.sv
// Self-checking bench for ccr_unit: directed vector table, hand-written stack
// corner sequences, and randomized traffic against a queue-based reference model.
module tb_ccr_unit;

  localparam int unsigned DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       alu_c = 1'b0, alu_v = 1'b0, alu_n = 1'b0, alu_z = 1'b0;
  logic       flag_we = 1'b0;
  logic [1:0] cond_sel = 2'd0;
  logic       branch_req = 1'b0;
  logic       branch_taken;
  logic       save = 1'b0, restore = 1'b0;
  logic       flag_c, flag_v, flag_n, flag_z;
  logic       stack_full, stack_empty, err;

  ccr_unit #(.STACK_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_c(alu_c), .alu_v(alu_v), .alu_n(alu_n), .alu_z(alu_z),
    .flag_we(flag_we), .cond_sel(cond_sel), .branch_req(branch_req),
    .branch_taken(branch_taken), .save(save), .restore(restore),
    .flag_c(flag_c), .flag_v(flag_v), .flag_n(flag_n), .flag_z(flag_z),
    .stack_full(stack_full), .stack_empty(stack_empty), .err(err)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nmis = 0;

  // Reference model: flags as a {Z,N,C,V} nibble, stack as a queue (back = top).
  logic [3:0] m_ccr;
  logic [3:0] m_q[$];
  logic       m_err;

  typedef struct {
    logic       fwe;
    logic [3:0] alu;
    logic [1:0] sel;
    logic       br;
    logic       sv;
    logic       rs;
    logic       taken;
    logic [3:0] flags;
    logic       empty;
    logic       full;
    logic       err;
  } vec_t;

  vec_t tbl[12];

  function automatic logic [3:0] dut_flags();
    return {flag_z, flag_n, flag_c, flag_v};
  endfunction

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic fwe, input logic [3:0] alu, input logic [1:0] sel,
                       input logic br, input logic sv, input logic rs);
    flag_we = fwe;
    {alu_z, alu_n, alu_c, alu_v} = alu;
    cond_sel = sel;
    branch_req = br;
    save = sv;
    restore = rs;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_ccr = 4'b0000;
    m_q.delete();
    m_err = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(1'b0, 4'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    rst_n = 1'b1;
    model_reset();
  endtask

  function automatic logic m_cond(input logic [1:0] sel);
    case (sel)
      2'd0: return m_ccr[3];
      2'd1: return m_ccr[2];
      2'd2: return m_ccr[1];
      default: return m_ccr[0];
    endcase
  endfunction

  task automatic model_step(input logic fwe, input logic [3:0] alu, input logic [1:0] sel,
                            input logic br, input logic sv, input logic rs);
    logic [3:0] old;
    logic [3:0] nv;
    logic       tk;
    old = m_ccr;
    tk  = br && m_cond(sel);
    nv  = fwe ? alu : m_ccr;
    if (tk) begin
      case (sel)
        2'd0: nv = nv & 4'b0111;
        2'd1: nv = nv & 4'b1011;
        2'd2: nv = nv & 4'b1101;
        default: nv = nv & 4'b1110;
      endcase
    end
    if (sv && rs) begin
      m_err = 1'b1;
      m_ccr = nv;
    end else if (rs) begin
      if (m_q.size() > 0) m_ccr = m_q.pop_back();
      else begin
        m_err = 1'b1;
        m_ccr = nv;
      end
    end else begin
      m_ccr = nv;
      if (sv) begin
        if (m_q.size() < DEPTH) m_q.push_back(old);
        else m_err = 1'b1;
      end
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_flags"}, dut_flags(), 4'b0000);
    chk({tag, "_empty"}, {3'b0, stack_empty}, 4'd1);
    chk({tag, "_full"}, {3'b0, stack_full}, 4'd0);
    chk({tag, "_err"}, {3'b0, err}, 4'd0);
    chk({tag, "_taken"}, {3'b0, branch_taken}, 4'd0);
  endtask

  logic [3:0] seqv[5];

  initial begin
    //               fwe   alu      sel   br    sv    rs    taken flags    empty full  err
    tbl[0]  = '{1'b1, 4'b1010, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1010, 1'b1, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 4'b0000, 2'd0, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0010, 1'b1, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 4'b0000, 2'd3, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0010, 1'b1, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 4'b0010, 2'd2, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0000, 1'b1, 1'b0, 1'b0};
    tbl[4]  = '{1'b1, 4'b0101, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0101, 1'b1, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, 4'b1010, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 4'b1010, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{1'b1, 4'b1111, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 4'b1111, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 4'b0000, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 4'b1111, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 4'b1111, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{1'b1, 4'b0000, 2'd0, 1'b1, 1'b0, 1'b1, 1'b1, 4'b1010, 1'b0, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0101, 1'b1, 1'b0, 1'b0};
    tbl[11] = '{1'b1, 4'b0011, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0011, 1'b1, 1'b0, 1'b1};

    // Reset state, with a branch request pending to observe branch_taken.
    rst_n = 1'b0;
    drive(1'b0, 4'b0, 2'd0, 1'b1, 1'b0, 1'b0);
    chk_reset_outputs("rst0");
    do_reset();

    for (int i = 0; i < 12; i++) begin
      drive(tbl[i].fwe, tbl[i].alu, tbl[i].sel, tbl[i].br, tbl[i].sv, tbl[i].rs);
      chk($sformatf("tbl%0d_taken", i), {3'b0, branch_taken}, {3'b0, tbl[i].taken});
      tick();
      chk($sformatf("tbl%0d_flags", i), dut_flags(), tbl[i].flags);
      chk($sformatf("tbl%0d_empty", i), {3'b0, stack_empty}, {3'b0, tbl[i].empty});
      chk($sformatf("tbl%0d_full", i), {3'b0, stack_full}, {3'b0, tbl[i].full});
      chk($sformatf("tbl%0d_err", i), {3'b0, err}, {3'b0, tbl[i].err});
    end

    // Fill to capacity, overflow, then drain past empty.
    do_reset();
    seqv[0] = 4'b0001; seqv[1] = 4'b0010; seqv[2] = 4'b0100;
    seqv[3] = 4'b1000; seqv[4] = 4'b0011;
    drive(1'b1, seqv[0], 2'd0, 1'b0, 1'b0, 1'b0);
    tick();
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, seqv[k+1], 2'd0, 1'b0, 1'b1, 1'b0);
      tick();
      chk($sformatf("fill%0d_full", k), {3'b0, stack_full}, (k == 3) ? 4'd1 : 4'd0);
    end
    chk("fill_flags", dut_flags(), 4'b0011);
    chk("fill_err", {3'b0, err}, 4'd0);
    drive(1'b0, 4'b0, 2'd0, 1'b0, 1'b1, 1'b0);
    tick();
    chk("ovf_err", {3'b0, err}, 4'd1);
    chk("ovf_full", {3'b0, stack_full}, 4'd1);
    chk("ovf_flags", dut_flags(), 4'b0011);
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 4'b0, 2'd0, 1'b0, 1'b0, 1'b1);
      tick();
      chk($sformatf("drain%0d_flags", k), dut_flags(), seqv[3-k]);
    end
    drive(1'b0, 4'b0, 2'd0, 1'b0, 1'b0, 1'b1);
    tick();
    chk("udf_flags", dut_flags(), 4'b0001);
    chk("udf_err", {3'b0, err}, 4'd1);
    chk("udf_empty", {3'b0, stack_empty}, 4'd1);

    // Save/restore collision at count 2, then asynchronous reset mid-cycle.
    do_reset();
    drive(1'b1, 4'b0110, 2'd0, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 4'b1001, 2'd0, 1'b0, 1'b1, 1'b0);
    tick();
    drive(1'b0, 4'b0000, 2'd0, 1'b0, 1'b1, 1'b0);
    tick();
    drive(1'b1, 4'b1100, 2'd0, 1'b0, 1'b1, 1'b1);
    tick();
    chk("col_flags", dut_flags(), 4'b1100);
    chk("col_err", {3'b0, err}, 4'd1);
    chk("col_empty", {3'b0, stack_empty}, 4'd0);
    chk("col_full", {3'b0, stack_full}, 4'd0);
    drive(1'b0, 4'b0, 2'd0, 1'b0, 1'b0, 1'b1);
    tick();
    chk("col_pop1", dut_flags(), 4'b1001);
    chk("col_pop1_empty", {3'b0, stack_empty}, 4'd0);
    tick();
    chk("col_pop2", dut_flags(), 4'b0110);
    chk("col_pop2_empty", {3'b0, stack_empty}, 4'd1);
    drive(1'b1, 4'b0111, 2'd0, 1'b1, 1'b1, 1'b0);
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("arst");
    drive(1'b0, 4'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    model_reset();
    tick();
    chk_reset_outputs("arst_post");

    // Randomized traffic against the reference model, alternating fill/drain bias.
    for (int i = 0; i < 800; i++) begin
      logic       fwe, br, sv, rs, exp_tk;
      logic [3:0] alu;
      logic [1:0] sel;
      int unsigned bias;
      bias = ((i / 40) % 2 == 0) ? 50 : 15;
      fwe = 1'($urandom_range(0, 1));
      alu = 4'($urandom);
      sel = 2'($urandom);
      br  = 1'($urandom_range(0, 1));
      sv  = ($urandom_range(0, 99) < bias);
      rs  = ($urandom_range(0, 99) < 65 - bias);
      if ($urandom_range(0, 99) < 3) begin
        sv = 1'b1;
        rs = 1'b1;
      end
      drive(fwe, alu, sel, br, sv, rs);
      exp_tk = br && m_cond(sel);
      chk("rnd_taken", {3'b0, branch_taken}, {3'b0, exp_tk});
      tick();
      model_step(fwe, alu, sel, br, sv, rs);
      chk("rnd_flags", dut_flags(), m_ccr);
      chk("rnd_empty", {3'b0, stack_empty}, {3'b0, (m_q.size() == 0)});
      chk("rnd_full", {3'b0, stack_full}, {3'b0, (m_q.size() == DEPTH)});
      chk("rnd_err", {3'b0, err}, {3'b0, m_err});
      if (i % 200 == 199) begin
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("rnd_arst");
        rst_n = 1'b1;
        model_reset();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
